// File: rtl/seq_multiplier_sm_if.sv
// Handshake and data bundle between a producer/consumer and seq_multiplier_sm.
// The master side drives requests and accepts results; the slave side is the multiplier.
interface seq_multiplier_sm_if #(
    parameter int WIDTH = 8
) ();
    logic               start;
    logic               ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               m_signed;
    logic               q_signed;
    logic               abort;
    logic [2*WIDTH-1:0] product;
    logic               product_valid;
    logic               product_ready;
    logic               busy;

    modport master (
        output start, multiplicand, multiplier, m_signed, q_signed, abort, product_ready,
        input  ready, product, product_valid, busy
    );

    modport slave (
        input  start, multiplicand, multiplier, m_signed, q_signed, abort, product_ready,
        output ready, product, product_valid, busy
    );
endinterface

// File: rtl/seq_multiplier_sm.sv
// Iterative shift-add multiplier with per-operand signedness and valid/ready handshakes.
// Both operands are widened by one bit so every signedness mix runs as one signed multiply.
module seq_multiplier_sm #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    seq_multiplier_sm_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        CALC = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   m_op, q_op;
    logic               m_sgn, q_sgn;
    logic [WIDTH:0]     mext, qsh;
    logic [WIDTH+1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;

    logic               accept, last;
    logic [WIDTH+1:0]   addend, sum, acc_n;
    logic [WIDTH:0]     qsh_n;

    assign accept = (state == IDLE) && bus.start && !bus.abort;
    assign last   = (cnt == '0);

    // The final iteration weights the extended multiplier MSB negatively, hence the subtract.
    always_comb begin
        addend = {mext[WIDTH], mext};
        sum    = acc;
        if (qsh[0])
            sum = last ? (acc - addend) : (acc + addend);
        acc_n  = {sum[WIDTH+1], sum[WIDTH+1:1]};
        qsh_n  = {sum[0], qsh[WIDTH:1]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state        = state;
        bus.ready         = 1'b0;
        bus.busy          = 1'b0;
        bus.product_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (accept)
                    next_state = LOAD;
            end
            LOAD: begin
                bus.busy   = 1'b1;
                next_state = bus.abort ? IDLE : CALC;
            end
            CALC: begin
                bus.busy = 1'b1;
                if (bus.abort)
                    next_state = IDLE;
                else if (last)
                    next_state = DONE;
            end
            DONE: begin
                bus.product_valid = 1'b1;
                if (bus.abort || bus.product_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_op  <= '0;
            q_op  <= '0;
            m_sgn <= 1'b0;
            q_sgn <= 1'b0;
            mext  <= '0;
            qsh   <= '0;
            acc   <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_op  <= bus.multiplicand;
                        q_op  <= bus.multiplier;
                        m_sgn <= bus.m_signed;
                        q_sgn <= bus.q_signed;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        prod <= '0;
                    end else begin
                        mext <= {m_sgn & m_op[WIDTH-1], m_op};
                        qsh  <= {q_sgn & q_op[WIDTH-1], q_op};
                        acc  <= '0;
                        cnt  <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        prod <= '0;
                    end else begin
                        acc <= acc_n;
                        qsh <= qsh_n;
                        cnt <= cnt - CNT_W'(1);
                        if (last)
                            prod <= {acc_n[WIDTH-2:0], qsh_n};
                    end
                end
                DONE: begin
                    if (bus.abort)
                        prod <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.product = prod;
endmodule

// File: tb/tb_seq_multiplier_sm.sv
// Bench for seq_multiplier_sm: directed WIDTH=4 scenarios and a randomized WIDTH=8 run
// against an integer-arithmetic reference product.
module tb_seq_multiplier_sm;
    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    seq_multiplier_sm_if #(.WIDTH(4)) if4 ();
    seq_multiplier_sm_if #(.WIDTH(8)) if8 ();

    seq_multiplier_sm #(.WIDTH(4)) dut4 (.clock(clock), .reset(reset), .bus(if4));
    seq_multiplier_sm #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(if8));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Interpret each operand by its signedness flag, multiply, keep 2*w bits.
    function automatic longint ref_mul(input int w, input longint m, input longint q,
                                       input bit ms, input bit qs);
        longint vm, vq, mask;
        vm = m;
        vq = q;
        if (ms && m[w-1]) vm = m - (longint'(1) << w);
        if (qs && q[w-1]) vq = q - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        return (vm * vq) & mask;
    endfunction

    // Issues one WIDTH=4 request from a negedge, returns product and edges-after-accept.
    task automatic run4(input logic [3:0] m, input logic [3:0] q, input logic ms, input logic qs,
                        output logic [7:0] p, output int lat);
        lat = -1;
        p   = 'x;
        if4.multiplicand = m;
        if4.multiplier   = q;
        if4.m_signed     = ms;
        if4.q_signed     = qs;
        if4.start        = 1'b1;
        for (int e = 0; e < 30 && lat < 0; e++) begin
            @(negedge clock);
            if4.start = 1'b0;
            if (if4.product_valid === 1'b1) begin
                lat = e;
                p   = if4.product;
            end
        end
        if4.product_ready = 1'b1;
        @(negedge clock);
        if4.product_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {if4.start, if4.abort, if4.product_ready, if4.m_signed, if4.q_signed} = '0;
        {if8.start, if8.abort, if8.product_ready, if8.m_signed, if8.q_signed} = '0;
        if4.multiplicand = '0; if4.multiplier = '0;
        if8.multiplicand = '0; if8.multiplier = '0;
        repeat (2) @(negedge clock);
        checks++; if (if4.ready !== 1'b1) begin failures++; $display("FAIL reset_ready4 got=%b exp=1", if4.ready); end
        checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy4 got=%b exp=0", if4.busy); end
        checks++; if (if4.product_valid !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%b exp=0", if4.product_valid); end
        checks++; if (if4.product !== 8'h00) begin failures++; $display("FAIL reset_product4 got=%h exp=00", if4.product); end
        checks++; if (if8.ready !== 1'b1) begin failures++; $display("FAIL reset_ready8 got=%b exp=1", if8.ready); end
        checks++; if (if8.product !== 16'h0000) begin failures++; $display("FAIL reset_product8 got=%h exp=0000", if8.product); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_unsigned();
        if4.multiplicand = 4'd13; if4.multiplier = 4'd11;
        if4.m_signed = 1'b0; if4.q_signed = 1'b0;
        if4.start = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clock);
            if4.start = 1'b0;
            checks++; if (if4.ready !== 1'b0) begin failures++; $display("FAIL uu_ready e=%0d got=%b exp=0", e, if4.ready); end
            checks++; if (if4.product_valid !== (e == 6)) begin failures++; $display("FAIL uu_valid e=%0d got=%b exp=%b", e, if4.product_valid, (e == 6)); end
        end
        checks++; if (if4.product !== 8'h8F) begin failures++; $display("FAIL uu_product got=%h exp=8f", if4.product); end
        if4.product_ready = 1'b1;
        @(negedge clock);
        if4.product_ready = 1'b0;
        checks++; if (if4.ready !== 1'b1) begin failures++; $display("FAIL uu_ready_after got=%b exp=1", if4.ready); end
    endtask

    task automatic test_signed();
        logic [7:0] p;
        int lat;
        run4(4'h8, 4'h8, 1'b1, 1'b1, p, lat);
        checks++; if (p !== 8'h40) begin failures++; $display("FAIL ss_m8xm8 got=%h exp=40", p); end
        checks++; if (lat !== 6) begin failures++; $display("FAIL ss_latency got=%0d exp=6", lat); end
        run4(4'hD, 4'h5, 1'b1, 1'b1, p, lat);
        checks++; if (p !== 8'hF1) begin failures++; $display("FAIL ss_m3x5 got=%h exp=f1", p); end
    endtask

    task automatic test_mixed();
        logic [7:0] p;
        int lat;
        run4(4'hF, 4'hF, 1'b1, 1'b0, p, lat);
        checks++; if (p !== 8'hF1) begin failures++; $display("FAIL mix_su got=%h exp=f1", p); end
        run4(4'hF, 4'hF, 1'b0, 1'b1, p, lat);
        checks++; if (p !== 8'hF1) begin failures++; $display("FAIL mix_us got=%h exp=f1", p); end
        run4(4'hF, 4'hF, 1'b0, 1'b0, p, lat);
        checks++; if (p !== 8'hE1) begin failures++; $display("FAIL mix_uu_max got=%h exp=e1", p); end
    endtask

    task automatic test_stall();
        bit seen = 0;
        if4.multiplicand = 4'd13; if4.multiplier = 4'd11;
        if4.m_signed = 1'b0; if4.q_signed = 1'b0;
        if4.start = 1'b1;
        for (int e = 0; e < 20 && !seen; e++) begin
            @(negedge clock);
            if4.start = 1'b0;
            seen = (if4.product_valid === 1'b1);
        end
        checks++; if (!seen) begin failures++; $display("FAIL stall_timeout got=no_valid exp=valid"); end
        for (int c = 0; c < 10; c++) begin
            if4.multiplicand = 4'd3; if4.multiplier = 4'd3;
            if4.start = 1'b1;
            @(negedge clock);
            checks++; if (if4.product_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, if4.product_valid); end
            checks++; if (if4.product !== 8'h8F) begin failures++; $display("FAIL stall_product c=%0d got=%h exp=8f", c, if4.product); end
        end
        if4.start = 1'b0;
        if4.product_ready = 1'b1;
        @(negedge clock);
        if4.product_ready = 1'b0;
        checks++; if (if4.ready !== 1'b1) begin failures++; $display("FAIL stall_ready got=%b exp=1", if4.ready); end
        checks++; if (if4.product_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_drop got=%b exp=0", if4.product_valid); end
        checks++; if (if4.product !== 8'h8F) begin failures++; $display("FAIL stall_hold got=%h exp=8f", if4.product); end
        @(negedge clock);
        checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL stall_no_accept got=%b exp=0", if4.busy); end
    endtask

    task automatic test_abort();
        logic [7:0] p;
        int lat;
        if4.multiplicand = 4'd13; if4.multiplier = 4'd11;
        if4.m_signed = 1'b0; if4.q_signed = 1'b0;
        if4.start = 1'b1;
        for (int e = 0; e <= 2; e++) begin
            @(negedge clock);
            if4.start = 1'b0;
            checks++; if (if4.product_valid !== 1'b0) begin failures++; $display("FAIL abort_valid e=%0d got=%b exp=0", e, if4.product_valid); end
        end
        if4.abort = 1'b1;
        @(negedge clock);
        if4.abort = 1'b0;
        checks++; if (if4.ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", if4.ready); end
        checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", if4.busy); end
        checks++; if (if4.product_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", if4.product_valid); end
        checks++; if (if4.product !== 8'h00) begin failures++; $display("FAIL abort_product got=%h exp=00", if4.product); end
        run4(4'd7, 4'd9, 1'b0, 1'b0, p, lat);
        checks++; if (p !== 8'h3F) begin failures++; $display("FAIL abort_next got=%h exp=3f", p); end
        checks++; if (lat !== 6) begin failures++; $display("FAIL abort_next_lat got=%0d exp=6", lat); end
        if4.start = 1'b1;
        if4.abort = 1'b1;
        @(negedge clock);
        if4.start = 1'b0;
        if4.abort = 1'b0;
        checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL start_abort_idle got=%b exp=0", if4.busy); end
        checks++; if (if4.ready !== 1'b1) begin failures++; $display("FAIL start_abort_ready got=%b exp=1", if4.ready); end
    endtask

    task automatic test_async_reset();
        if8.multiplicand = 8'($urandom); if8.multiplier = 8'($urandom);
        if8.m_signed = 1'($urandom); if8.q_signed = 1'($urandom);
        if8.start = 1'b1;
        @(negedge clock);
        if8.start = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (if8.busy !== 1'b1) begin failures++; $display("FAIL areset_pre_busy got=%b exp=1", if8.busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (if8.ready !== 1'b1) begin failures++; $display("FAIL areset_ready got=%b exp=1", if8.ready); end
        checks++; if (if8.busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", if8.busy); end
        checks++; if (if8.product_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", if8.product_valid); end
        checks++; if (if8.product !== 16'h0000) begin failures++; $display("FAIL areset_product got=%h exp=0000", if8.product); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (if8.ready !== 1'b1) begin failures++; $display("FAIL areset_after got=%b exp=1", if8.ready); end
    endtask

    task automatic test_regression();
        for (int n = 0; n < 1000; n++) begin
            logic [7:0]  m, q;
            logic        ms, qs;
            logic [15:0] exp;
            int          seen;
            bit          done;
            m  = 8'($urandom);
            q  = 8'($urandom);
            ms = 1'($urandom);
            qs = 1'($urandom);
            if (n == 0) begin m = 8'hFF; q = 8'hFF; ms = 1'b0; qs = 1'b0; end
            if (n == 1) begin m = 8'h80; q = 8'h80; ms = 1'b1; qs = 1'b1; end
            if (n == 2) begin m = 8'h80; q = 8'h7F; ms = 1'b1; qs = 1'b1; end
            exp = 16'(ref_mul(8, longint'(m), longint'(q), ms, qs));
            checks++; if (if8.ready !== 1'b1) begin failures++; $display("FAIL reg_ready n=%0d got=%b exp=1", n, if8.ready); end
            if8.multiplicand = m; if8.multiplier = q;
            if8.m_signed = ms; if8.q_signed = qs;
            if8.start = 1'b1;
            seen = -1;
            done = 0;
            for (int e = 0; e < 40 && !done; e++) begin
                @(negedge clock);
                if8.start = 1'b0;
                if (if8.product_valid === 1'b1) begin
                    if (seen < 0) begin
                        seen = e;
                        checks++; if (seen !== 10) begin failures++; $display("FAIL reg_latency n=%0d got=%0d exp=10", n, seen); end
                    end
                    checks++; if (if8.product !== exp) begin failures++; $display("FAIL reg_product n=%0d m=%h q=%h ms=%b qs=%b got=%h exp=%h", n, m, q, ms, qs, if8.product, exp); end
                    if8.product_ready = 1'($urandom);
                    done = (if8.product_ready == 1'b1);
                end else begin
                    if8.product_ready = 1'($urandom);
                end
            end
            if (!done) begin
                checks++; failures++; $display("FAIL reg_timeout n=%0d got=no_transfer exp=transfer", n);
            end
            @(negedge clock);
            if8.product_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_mixed();
        test_stall();
        test_abort();
        test_async_reset();
        test_regression();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_multiplier_sm.md
Name: seq_multiplier_sm

Overview:
Parametrised next-generation iterative shift-add multiplier for the arithmetic datapath. It multiplies two WIDTH-bit operands, and each operand is selectable per transaction as signed (two's complement) or unsigned. The result is a 2*WIDTH-bit product. Input and output both use valid/ready-style handshakes, so the block sits between a producer and a consumer that may stall; the result is held until consumed; a synchronous abort is supported.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request: operands valid this cycle
ready  output  1  block can accept a request (IDLE only)
multiplicand  input  WIDTH  operand M
multiplier  input  WIDTH  operand Q
m_signed  input  1  1: multiplicand is two's complement; 0: unsigned
q_signed  input  1  1: multiplier is two's complement; 0: unsigned
abort  input  1  synchronous cancel of the current operation
product  output  2*WIDTH  result, valid when product_valid=1
product_valid  output  1  result available
product_ready  input  1  consumer accepts result
busy  output  1  1 in LOAD or CALC

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - ready=1, product_valid=0, busy=0, product=0.
  - All internal registers = 0.
- States: IDLE, LOAD, CALC, DONE.
  - One-hot encoding, 4 bits.
  - Moore outputs: ready=(IDLE), busy=(LOAD|CALC), product_valid=(DONE).
- IDLE:
  - On start=1, capture multiplicand, multiplier, m_signed, q_signed into internal registers (accept edge) -> LOAD.
  - Otherwise stay.
- LOAD (1 cycle):
  - Extend each operand to WIDTH+1 bits: sign-extend if its signed flag is set, else zero-extend.
  - Clear accumulator A (WIDTH+2 bits, sign-extended).
  - Counter = WIDTH.
  - -> CALC.
- CALC (exactly WIDTH+1 cycles), each cycle:
  - If Q[0]=1, A += Mext. On the final iteration (counter==0) subtract instead: A -= Mext, which handles a negative extended multiplier MSB.
  - Arithmetic right shift of {A,Q} by 1, sign bit of A preserved.
  - Counter decrements each cycle; on the cycle counter==0, -> DONE.
- DONE:
  - product = low 2*WIDTH bits of the accumulated {A,Q}, registered and stable while product_valid=1.
  - Transfer occurs on an edge with product_valid & product_ready -> IDLE.
  - product holds its last value in IDLE (not cleared).
- Latency:
  - product_valid rises WIDTH+2 edges after the accept edge.
  - Minimum issue interval is WIDTH+4 cycles (ready returns one cycle after the transfer edge).
  - start is ignored while ready=0.
- Abort:
  - abort=1 in LOAD, CALC or DONE -> IDLE on the next edge; product_valid drops and product is cleared to 0.
  - abort=1 in IDLE has no effect; abort has priority over start.
- Simultaneous start and abort in IDLE: request not accepted.
- Width rules:
  - Product is exact for all four signedness combinations; no overflow is possible.
  - Unsigned x unsigned with both operands = 2^WIDTH-1 gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1.
- Reset mid-operation: immediate return to IDLE; no partial result is visible.
- product_ready while product_valid=0: ignored.

Test Plan:
- WIDTH=4, unsigned x unsigned, 13 x 11 -> product=8'h8F (143), product_valid rises 6 edges after accept, ready=0 throughout.
- WIDTH=4, signed x signed, -8 x -8 (4'h8,4'h8) -> 8'h40 (+64); -3 x 5 -> 8'hF1 (-15).
- WIDTH=4, mixed modes: m_signed=1 (4'hF = -1) x q_signed=0 (4'hF = 15) -> 8'hF1 (-15); reverse flags -> same 8'hF1; both unsigned 4'hF x 4'hF -> 8'hE1 (225).
- Output stall: hold product_ready=0 for 10 cycles in DONE -> product_valid and product stable, start ignored; product_ready=1 -> IDLE, ready=1 next cycle.
- Abort mid-CALC (2 cycles into CALC) -> IDLE next edge, product=0, product_valid never asserted; next request 7 x 9 unsigned -> 8'h3F with normal latency.
- Async reset asserted mid-CALC between clock edges -> ready=1, busy=0, product_valid=0 immediately; WIDTH=8 regression with random operands/modes vs reference model over 1000 transactions with random product_ready stalls.
